// File: rtl/lsu_rdata_buf.sv
// In-order load/store response buffer between the data-memory port and writeback.
// Requests allocate entries, responses fill the oldest unfilled one, the head is formatted and popped.
module lsu_rdata_buf #(
    parameter int unsigned Depth       = 2,
    parameter bit          FallThrough = 1'b0,
    localparam int unsigned PtrW       = $clog2(Depth),
    localparam int unsigned CntW       = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_push_i,
    input  logic            req_we_i,
    input  logic [1:0]      req_type_i,
    input  logic            req_sign_ext_i,
    input  logic [1:0]      req_offset_i,
    output logic            req_ready_o,
    input  logic            data_rvalid_i,
    input  logic [31:0]     data_rdata_i,
    input  logic            data_err_i,
    output logic            lsu_rvalid_o,
    input  logic            lsu_rready_i,
    output logic [31:0]     lsu_rdata_o,
    output logic            lsu_err_o,
    output logic            lsu_we_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            protocol_err_o
);

    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    logic            r_we     [Depth];
    logic [1:0]      r_type   [Depth];
    logic            r_sext   [Depth];
    logic [1:0]      r_off    [Depth];
    logic            r_filled [Depth];
    logic [31:0]     r_rdata  [Depth];
    logic            r_err    [Depth];

    logic [PtrW-1:0] r_allocPtr;
    logic [PtrW-1:0] r_fillPtr;
    logic [PtrW-1:0] r_headPtr;
    logic [CntW-1:0] r_count;
    logic [CntW-1:0] r_unfilled;
    logic            r_protErr;

    logic            w_full;
    logic            w_push;
    logic            w_fill;
    logic            w_fallThru;
    logic            w_valid;
    logic            w_pop;
    logic [31:0]     w_rawData;
    logic            w_rawErr;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_misaligned;
    logic [31:0]     w_fmtData;

    // Fullness comes from the count; pointers alone cannot distinguish full from empty.
    assign w_full   = (r_count == DepthC);
    assign w_push   = req_push_i && !w_full;
    assign w_fill   = data_rvalid_i && (r_unfilled != '0);
    assign w_fallThru = FallThrough && w_fill && (r_fillPtr == r_headPtr) && (r_count != '0);
    assign w_valid  = (r_filled[r_headPtr] && (r_count != '0)) || w_fallThru;
    assign w_pop    = w_valid && lsu_rready_i;

    assign w_rawData = w_fallThru ? data_rdata_i : r_rdata[r_headPtr];
    assign w_rawErr  = w_fallThru ? data_err_i   : r_err[r_headPtr];

    always_comb begin
        w_byte       = 8'h00;
        w_half       = 16'h0000;
        w_misaligned = 1'b0;
        w_fmtData    = 32'h0;
        case (r_off[r_headPtr])
            2'd0:    w_byte = w_rawData[7:0];
            2'd1:    w_byte = w_rawData[15:8];
            2'd2:    w_byte = w_rawData[23:16];
            default: w_byte = w_rawData[31:24];
        endcase
        case (r_off[r_headPtr])
            2'd0:    w_half = w_rawData[15:0];
            2'd1:    w_half = w_rawData[23:8];
            2'd2:    w_half = w_rawData[31:16];
            default: w_half = 16'h0000;
        endcase
        case (r_type[r_headPtr])
            2'b10: w_fmtData = {{24{r_sext[r_headPtr] & w_byte[7]}}, w_byte};
            2'b01: begin
                w_misaligned = (r_off[r_headPtr] == 2'd3);
                w_fmtData    = {{16{r_sext[r_headPtr] & w_half[15]}}, w_half};
            end
            default: begin
                w_misaligned = (r_off[r_headPtr] != 2'd0);
                w_fmtData    = w_rawData;
            end
        endcase
    end

    // Stores carry only the bus error; loads also flag misalignment and blank their data.
    always_comb begin
        lsu_rvalid_o = w_valid;
        lsu_rdata_o  = 32'h0;
        lsu_err_o    = 1'b0;
        lsu_we_o     = 1'b0;
        if (w_valid) begin
            lsu_we_o = r_we[r_headPtr];
            if (r_we[r_headPtr]) begin
                lsu_err_o = w_rawErr;
            end else begin
                lsu_err_o   = w_rawErr | w_misaligned;
                lsu_rdata_o = w_misaligned ? 32'h0 : w_fmtData;
            end
        end
    end

    assign req_ready_o    = !w_full;
    assign outstanding_o  = r_count;
    assign protocol_err_o = r_protErr;

    // The pop clear is written last so it wins when a fall-through fill and pop hit the same entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_we[i]     <= 1'b0;
                r_type[i]   <= 2'b00;
                r_sext[i]   <= 1'b0;
                r_off[i]    <= 2'b00;
                r_filled[i] <= 1'b0;
                r_rdata[i]  <= 32'h0;
                r_err[i]    <= 1'b0;
            end
            r_allocPtr <= '0;
            r_fillPtr  <= '0;
            r_headPtr  <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_protErr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_we[r_allocPtr]     <= req_we_i;
                r_type[r_allocPtr]   <= req_type_i;
                r_sext[r_allocPtr]   <= req_sign_ext_i;
                r_off[r_allocPtr]    <= req_offset_i;
                r_filled[r_allocPtr] <= 1'b0;
                r_allocPtr           <= r_allocPtr + 1'b1;
            end
            if (w_fill) begin
                r_rdata[r_fillPtr]  <= data_rdata_i;
                r_err[r_fillPtr]    <= data_err_i;
                r_filled[r_fillPtr] <= 1'b1;
                r_fillPtr           <= r_fillPtr + 1'b1;
            end else if (data_rvalid_i) begin
                r_protErr <= 1'b1;
            end
            if (w_pop) begin
                r_filled[r_headPtr] <= 1'b0;
                r_headPtr           <= r_headPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_push, w_fill})
                2'b10:   r_unfilled <= r_unfilled + 1'b1;
                2'b01:   r_unfilled <= r_unfilled - 1'b1;
                default: r_unfilled <= r_unfilled;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rdata_buf.sv
// Directed testbench for lsu_rdata_buf: scoreboard of formatted responses, plus a fall-through instance.
module tb_lsu_rdata_buf;

    localparam int Depth = 2;

    typedef struct packed {
        logic       we;
        logic [1:0] typ;
        logic       sext;
        logic [1:0] off;
    } meta_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        we;
    } resp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqPush, reqWe, reqSext, dataRvalid, dataErr, lsuRready;
    logic [1:0]  reqType, reqOff;
    logic [31:0] dataRdata;
    logic        reqReady, lsuRvalid, lsuErr, lsuWe, protErr;
    logic [31:0] lsuRdata;
    logic [1:0]  outstanding;

    logic        ftPush, ftRvalid, ftRready;
    logic [31:0] ftRdata;
    logic        ftReqReady, ftLsuRvalid, ftLsuErr, ftLsuWe, ftProtErr;
    logic [31:0] ftLsuRdata;
    logic [1:0]  ftOutstanding;

    int          checks = 0;
    int          errors = 0;
    int          modelCount;
    logic        expProtErr;
    logic        expReady;
    meta_t       metaQ[$];
    resp_t       sbQ[$];
    resp_t       ftSbQ[$];
    resp_t       got;

    always #5 clk = ~clk;

    lsu_rdata_buf #(.Depth(Depth), .FallThrough(1'b0)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .req_push_i(reqPush), .req_we_i(reqWe), .req_type_i(reqType),
        .req_sign_ext_i(reqSext), .req_offset_i(reqOff), .req_ready_o(reqReady),
        .data_rvalid_i(dataRvalid), .data_rdata_i(dataRdata), .data_err_i(dataErr),
        .lsu_rvalid_o(lsuRvalid), .lsu_rready_i(lsuRready), .lsu_rdata_o(lsuRdata),
        .lsu_err_o(lsuErr), .lsu_we_o(lsuWe), .outstanding_o(outstanding),
        .protocol_err_o(protErr)
    );

    lsu_rdata_buf #(.Depth(Depth), .FallThrough(1'b1)) dutFt (
        .clk_i(clk), .rst_ni(rstN),
        .req_push_i(ftPush), .req_we_i(1'b0), .req_type_i(2'b00),
        .req_sign_ext_i(1'b0), .req_offset_i(2'b00), .req_ready_o(ftReqReady),
        .data_rvalid_i(ftRvalid), .data_rdata_i(ftRdata), .data_err_i(1'b0),
        .lsu_rvalid_o(ftLsuRvalid), .lsu_rready_i(ftRready), .lsu_rdata_o(ftLsuRdata),
        .lsu_err_o(ftLsuErr), .lsu_we_o(ftLsuWe), .outstanding_o(ftOutstanding),
        .protocol_err_o(ftProtErr)
    );

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic resp_t expectFor(input meta_t m, input logic [31:0] rd, input logic er);
        resp_t       r;
        logic [31:0] sh;
        r.we = m.we;
        sh   = rd >> (8 * m.off);
        if (m.we) begin
            r.data = 32'h0;
            r.err  = er;
        end else if (m.typ == 2'b10) begin
            r.data = {24'h0, sh[7:0]};
            if (m.sext && sh[7]) r.data = r.data | 32'hFFFF_FF00;
            r.err = er;
        end else if (m.typ == 2'b01) begin
            if (m.off == 2'd3) begin
                r.data = 32'h0;
                r.err  = 1'b1;
            end else begin
                r.data = {16'h0, sh[15:0]};
                if (m.sext && sh[15]) r.data = r.data | 32'hFFFF_0000;
                r.err = er;
            end
        end else begin
            if (m.off != 2'd0) begin
                r.data = 32'h0;
                r.err  = 1'b1;
            end else begin
                r.data = rd;
                r.err  = er;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs and updates the bench's own queue model.
    task automatic applyStimulus(input logic push, input logic we, input logic [1:0] typ,
                                 input logic sext, input logic [1:0] off, input logic rv,
                                 input logic [31:0] rd, input logic er, input logic rr);
        reqPush    = push;
        reqWe      = we;
        reqType    = typ;
        reqSext    = sext;
        reqOff     = off;
        dataRvalid = rv;
        dataRdata  = rd;
        dataErr    = er;
        lsuRready  = rr;
        expReady   = (modelCount < Depth);
        if (rv) begin
            if (metaQ.size() != 0) sbQ.push_back(expectFor(metaQ.pop_front(), rd, er));
            else expProtErr = 1'b1;
        end
        if (push && expReady) begin
            metaQ.push_back('{we: we, typ: typ, sext: sext, off: off});
            modelCount++;
        end
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, rr);
    endtask

    task automatic sampleOutputs();
        @(negedge clk);
        checkOutput("reqReady", reqReady, expReady);
        if (lsuRvalid && lsuRready) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedResp", lsuRdata, 32'h0);
                checkOutput("unexpectedRespValid", lsuRvalid, 1'b0);
            end else begin
                got = sbQ.pop_front();
                checkOutput("respData", lsuRdata, got.data);
                checkOutput("respErr", lsuErr, got.err);
                checkOutput("respWe", lsuWe, got.we);
                modelCount--;
            end
        end else if (!lsuRvalid) begin
            checkOutput("idleData", {lsuRdata[31:2], lsuErr, lsuWe}, 32'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sampleOutputs();
        tick();
    endtask

    task automatic loadOne(input logic we, input logic [1:0] typ, input logic sext,
                           input logic [1:0] off, input logic [31:0] rd, input logic er);
        applyStimulus(1'b1, we, typ, sext, off, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, rd, er, 1'b1);
        step();
        idle(1'b1);
        step();
    endtask

    initial begin
        modelCount = 0;
        expProtErr = 1'b0;
        expReady   = 1'b1;
        ftPush = 1'b0; ftRvalid = 1'b0; ftRready = 1'b0; ftRdata = 32'h0;
        rstN = 1'b1;
        idle(1'b0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstReady", reqReady, 1'b1);
        checkOutput("rstValid", lsuRvalid, 1'b0);
        checkOutput("rstData", lsuRdata, 32'h0);
        checkOutput("rstErrWe", {lsuErr, lsuWe}, 2'b00);
        checkOutput("rstOutstanding", outstanding, 2'd0);
        checkOutput("rstProtErr", protErr, 1'b0);
        tick();
        tick();
        rstN = 1'b1;

        // Word load: response is only visible one cycle after it is accepted.
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        checkOutput("pushOutstanding", outstanding, 2'd1);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        sampleOutputs();
        checkOutput("noFallThrough", lsuRvalid, 1'b0);
        tick();
        idle(1'b1);
        sampleOutputs();
        checkOutput("wordValid", lsuRvalid, 1'b1);
        tick();
        checkOutput("wordOutstanding", outstanding, 2'd0);

        loadOne(1'b0, 2'b10, 1'b1, 2'd2, 32'h0080_0000, 1'b0);
        loadOne(1'b0, 2'b10, 1'b0, 2'd2, 32'h0080_0000, 1'b0);
        loadOne(1'b0, 2'b01, 1'b0, 2'd3, 32'h1234_5678, 1'b0);
        loadOne(1'b0, 2'b01, 1'b1, 2'd2, 32'h8001_0000, 1'b0);
        loadOne(1'b0, 2'b10, 1'b1, 2'd1, 32'h0000_3400, 1'b0);
        loadOne(1'b0, 2'b00, 1'b0, 2'd1, 32'hCAFE_F00D, 1'b0);
        loadOne(1'b0, 2'b11, 1'b0, 2'd0, 32'h1357_9BDF, 1'b0);
        loadOne(1'b1, 2'b00, 1'b0, 2'd0, 32'hFFFF_FFFF, 1'b1);

        // Fill the queue: the third push must be dropped.
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checkOutput("readyLowFull", reqReady, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checkOutput("fullOutstanding", outstanding, 2'd2);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_0022, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            sampleOutputs();
            checkOutput("holdValid", lsuRvalid, 1'b1);
            checkOutput("holdData", lsuRdata, 32'h0000_0011);
            tick();
        end
        idle(1'b1);
        step();
        idle(1'b1);
        step();
        checkOutput("drainOutstanding", outstanding, 2'd0);

        // Overlapped traffic across another pointer wrap.
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 2'd3, 1'b1, 32'h0000_F00D, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 32'hAB00_0000, 1'b0, 1'b1);
        step();
        loadOne(1'b0, 2'b00, 1'b0, 2'd0, 32'h0123_4567, 1'b0);
        for (int i = 0; i < 8 && sbQ.size() != 0; i++) begin
            idle(1'b1);
            step();
        end
        checkOutput("sbDrained", sbQ.size(), 32'd0);
        checkOutput("wrapOutstanding", outstanding, 2'd0);

        // Orphan response sets the sticky protocol error.
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_0099, 1'b0, 1'b1);
        step();
        checkOutput("protErrSet", protErr, expProtErr);
        idle(1'b1);
        step();
        idle(1'b1);
        step();
        checkOutput("protErrHeld", protErr, 1'b1);

        // Asynchronous reset in the middle of a burst.
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
        step();
        idle(1'b0);
        sampleOutputs();
        checkOutput("preRstValid", lsuRvalid, 1'b1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midRstValid", lsuRvalid, 1'b0);
        checkOutput("midRstData", lsuRdata, 32'h0);
        checkOutput("midRstReady", reqReady, 1'b1);
        checkOutput("midRstOutstanding", outstanding, 2'd0);
        checkOutput("midRstProtErr", protErr, 1'b0);
        metaQ.delete();
        sbQ.delete();
        modelCount = 0;
        expProtErr = 1'b0;
        expReady   = 1'b1;
        tick();
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_0077, 1'b0, 1'b1);
        step();
        checkOutput("postRstProtErr", protErr, expProtErr);

        // Fall-through instance: response presented in the cycle it arrives.
        ftPush = 1'b1;
        tick();
        ftPush   = 1'b0;
        ftRvalid = 1'b1;
        ftRdata  = 32'hA5A5_A5A5;
        ftRready = 1'b1;
        ftSbQ.push_back('{data: 32'hA5A5_A5A5, err: 1'b0, we: 1'b0});
        #1;
        checkOutput("ftValid", ftLsuRvalid, 1'b1);
        checkOutput("ftOutstandingPre", ftOutstanding, 2'd1);
        if (ftLsuRvalid && ftRready && ftSbQ.size() != 0) begin
            got = ftSbQ.pop_front();
            checkOutput("ftData", ftLsuRdata, got.data);
            checkOutput("ftErrWe", {ftLsuErr, ftLsuWe}, {got.err, got.we});
        end
        tick();
        ftRvalid = 1'b0;
        #1;
        checkOutput("ftSbDrained", ftSbQ.size(), 32'd0);
        checkOutput("ftOutstandingPost", ftOutstanding, 2'd0);
        checkOutput("ftValidPost", ftLsuRvalid, 1'b0);
        checkOutput("ftProtErr", ftProtErr, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_rdata_buf.md
# lsu_rdata_buf

Parametrised load/store response buffer between the data-memory interface and the writeback stage. It replaces the single-register read-data capture with a Depth-entry in-order queue:
- Each granted request allocates an entry holding its access metadata.
- Each memory response fills the oldest unfilled entry with rdata and err.
- Filled entries are formatted (byte/halfword extraction, sign extension) and handed to writeback over a valid/ready handshake.

Memory responses are never back-pressured. The block guarantees space by limiting outstanding requests.

## Interface
Parameters:
- Depth, 2, number of entries, power of two, ≥ 2.
- FallThrough, 0, 1 = a response arriving for the head entry is presented combinationally in the same cycle.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_push_i  in  1  request granted this cycle; allocate an entry.
- req_we_i  in  1  request is a store.
- req_type_i  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- req_sign_ext_i  in  1  sign-extend the loaded byte or halfword.
- req_offset_i  in  2  addr[1:0] of the request.
- req_ready_o  out  1  entry available; upstream must not grant while low.
- data_rvalid_i  in  1  memory response valid.
- data_rdata_i  in  32  memory read data.
- data_err_i  in  1  memory bus error.
- lsu_rvalid_o  out  1  head entry filled and presented.
- lsu_rready_i  in  1  writeback accepts the head entry.
- lsu_rdata_o  out  32  formatted load data.
- lsu_err_o  out  1  bus error or misaligned access.
- lsu_we_o  out  1  head entry is a store response.
- outstanding_o  out  $clog2(Depth+1)  allocated entries not yet popped.
- protocol_err_o  out  1  sticky: a response arrived with no unfilled entry.

## Operation
- State is circular storage of Depth entries, each holding {we, type, sign_ext, offset, filled, rdata, err}, plus three pointers (alloc, fill, head) and a count.
- Allocate: req_push_i && req_ready_o writes metadata at alloc, clears filled, increments alloc. Push while full is ignored and the entry is not stored.
- Fill: data_rvalid_i with unfilled entries writes rdata/err at fill, sets filled, increments fill.
- Fill with no unfilled entry: discard the response and set protocol_err_o. protocol_err_o clears only on reset.
- Pop: lsu_rvalid_o && lsu_rready_i frees head and increments head.
- Allocate, fill and pop may all occur in the same cycle. The count update is +push −pop.
- req_ready_o = count < Depth. A push in the same cycle as a pop while full is not accepted.
- Formatting, taken from the head entry:
  - Word: offset ≠ 0 is misaligned; otherwise rdata passes through.
  - Halfword: offset 3 is misaligned; otherwise field = rdata[8·offset +: 16].
  - Byte: field = rdata[8·offset +: 8].
  - Zero-extend, or sign-extend when sign_ext is set, to 32 bits.
  - Misaligned: lsu_err_o = 1, lsu_rdata_o = 0.
  - Store: lsu_rdata_o = 0, lsu_err_o = err.
  - lsu_err_o = err OR misaligned.
- lsu_rdata_o, lsu_err_o and lsu_we_o are 0 whenever lsu_rvalid_o is 0.
- Wrap-around: all pointers wrap modulo Depth. Full/empty is decided from count, not from pointer equality.

## Timing
- Reset (asynchronous, immediate): pointers and count 0, all filled flags cleared.
  - req_ready_o = 1; all other outputs 0, including protocol_err_o.
  - Reset mid-operation discards every entry. Responses arriving after reset raise protocol_err_o.
- FallThrough = 0: a response accepted at edge N is first visible on lsu_rvalid_o after edge N. Minimum latency is one cycle.
- FallThrough = 1: if the fill pointer equals head and the queue is not empty, lsu_rvalid_o and the formatted data follow data_rvalid_i combinationally in the same cycle. A pop in that cycle frees the entry at the edge.
- lsu_rvalid_o stays high and outputs stay stable until popped.
- outstanding_o equals count and updates on the clock edge.

## Test plan
- Reset, then push a word load at offset 0 and respond with 0xDEADBEEF one cycle later, rready = 1 → lsu_rvalid_o one cycle after the response, rdata 0xDEADBEEF, err 0, outstanding_o returns to 0.
- Byte load, offset 2, sign_ext = 1, response 0x00800000 → rdata 0xFFFFFF80. Repeat with sign_ext = 0 → 0x00000080. Halfword load at offset 3 → err 1, rdata 0.
- Depth = 2: push 3 requests back-to-back with no responses → req_ready_o low after the second push, third push ignored, outstanding_o = 2.
- Push 2 requests, respond 0x11 then 0x22 with rready = 0 → both held and lsu_rvalid_o stays high; release rready → 0x11 then 0x22 in order. Then continue pushing and responding across a pointer wrap.
- Response with no outstanding request → protocol_err_o = 1 and held. Assert rst_ni low mid-burst → all outputs 0 immediately, req_ready_o = 1.
- FallThrough = 1, empty queue: push, then respond 0xA5A5A5A5 with rready = 1 → lsu_rvalid_o in the same cycle as data_rvalid_i, outstanding_o = 0 after the edge.
